// File: rtl/tx_packet_scheduler.sv
// rtl/tx_packet_scheduler.sv - two-channel round-robin scheduler feeding the transmit packetizer
module tx_packet_scheduler #(
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [15:0] req_len0,
   input  logic [15:0] req_len1,
   input  logic [1:0]  req_bpsk,
   output logic [1:0]  grant,
   output logic        src_sel,
   output logic [15:0] pkt_length,
   output logic        pkt_is_bpsk,
   output logic        pkt_en,
   input  logic        hdr_vld,
   input  logic        tx_tvalid,
   input  logic        tx_tready,
   input  logic        tx_tlast,
   output logic        busy,
   output logic        pkt_done,
   output logic        err_abort,
   output logic        err_zero_len
);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_HDR, BUSY, GAP} state_t;

   // Terminal counts: the gap counter and timeout counter both start at 0.
   localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        last_served;
   logic [15:0] gap_cnt;
   logic [15:0] to_cnt;

   logic        win;
   logic [15:0] win_len;
   logic        tlast_acc;
   logic        to_hit;

   assign tlast_acc = tx_tvalid & tx_tready & tx_tlast;
   assign to_hit    = (to_cnt == TIMEOUT_LAST);

   // Round-robin pick: a lone requester wins, on a tie the channel not served last wins.
   always_comb begin
      win = req[1];
      if (req == 2'b11) begin
         win = ~last_served;
      end
      win_len = win ? req_len1 : req_len0;
   end

   // Packet sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_served  <= 1'b1;
         gap_cnt      <= '0;
         to_cnt       <= '0;
         grant        <= 2'b00;
         src_sel      <= 1'b0;
         pkt_length   <= '0;
         pkt_is_bpsk  <= 1'b1;
         pkt_en       <= 1'b0;
         busy         <= 1'b0;
         pkt_done     <= 1'b0;
         err_abort    <= 1'b0;
         err_zero_len <= 1'b0;
      end else begin
         grant        <= 2'b00;
         pkt_done     <= 1'b0;
         err_abort    <= 1'b0;
         err_zero_len <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  grant       <= win ? 2'b10 : 2'b01;
                  src_sel     <= win;
                  pkt_length  <= win_len;
                  pkt_is_bpsk <= req_bpsk[win];
                  last_served <= win;
                  if (win_len == 16'd0) begin
                     // Nothing to send: drop the request and stay idle.
                     err_zero_len <= 1'b1;
                  end else begin
                     state  <= LOAD;
                     pkt_en <= 1'b1;
                     busy   <= 1'b1;
                  end
               end
            end
            LOAD: begin
               state  <= WAIT_HDR;
               to_cnt <= '0;
            end
            WAIT_HDR, BUSY: begin
               if (state == BUSY && tlast_acc) begin
                  // A tlast on the timeout cycle still completes the packet normally.
                  state    <= GAP;
                  pkt_done <= 1'b1;
                  pkt_en   <= 1'b0;
                  gap_cnt  <= '0;
               end else if (to_hit) begin
                  state     <= GAP;
                  err_abort <= 1'b1;
                  pkt_en    <= 1'b0;
                  gap_cnt   <= '0;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
                  if (state == WAIT_HDR && hdr_vld) begin
                     state <= BUSY;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            default: begin
               state  <= IDLE;
               pkt_en <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// tb/tb_tx_packet_scheduler.sv - self-checking bench for tx_packet_scheduler
module tb_tx_packet_scheduler;

   localparam int GAP = 4;
   localparam logic [24:0] RST_OUTS = {2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [15:0] req_len0 = 16'd0;
   logic [15:0] req_len1 = 16'd0;
   logic [1:0]  req_bpsk = 2'b00;
   logic        hdr_vld = 1'b0;
   logic        tx_tvalid = 1'b0;
   logic        tx_tready = 1'b0;
   logic        tx_tlast = 1'b0;

   logic [1:0]  grant;
   logic        src_sel;
   logic [15:0] pkt_length;
   logic        pkt_is_bpsk, pkt_en, busy, pkt_done, err_abort, err_zero_len;

   logic [1:0]  t_grant;
   logic        t_src_sel;
   logic [15:0] t_pkt_length;
   logic        t_pkt_is_bpsk, t_pkt_en, t_busy, t_pkt_done, t_err_abort, t_err_zero_len;

   int total = 0;
   int bad = 0;

   // packetizer model state
   int pz_phase = 0;
   int pz_wait = 0;
   int pz_hdr_dly = 0;
   int pz_len = 1;
   int pz_sent = 0;
   bit pz_stall = 1'b0;

   always #5 clk = ~clk;

   tx_packet_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(65535)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_len0(req_len0), .req_len1(req_len1),
      .req_bpsk(req_bpsk), .grant(grant), .src_sel(src_sel), .pkt_length(pkt_length),
      .pkt_is_bpsk(pkt_is_bpsk), .pkt_en(pkt_en), .hdr_vld(hdr_vld), .tx_tvalid(tx_tvalid),
      .tx_tready(tx_tready), .tx_tlast(tx_tlast), .busy(busy), .pkt_done(pkt_done),
      .err_abort(err_abort), .err_zero_len(err_zero_len)
   );

   tx_packet_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(50)) dut_to (
      .clk(clk), .rst_n(rst_n), .req(req), .req_len0(req_len0), .req_len1(req_len1),
      .req_bpsk(req_bpsk), .grant(t_grant), .src_sel(t_src_sel), .pkt_length(t_pkt_length),
      .pkt_is_bpsk(t_pkt_is_bpsk), .pkt_en(t_pkt_en), .hdr_vld(1'b0), .tx_tvalid(1'b0),
      .tx_tready(1'b0), .tx_tlast(1'b0), .busy(t_busy), .pkt_done(t_pkt_done),
      .err_abort(t_err_abort), .err_zero_len(t_err_zero_len)
   );

   typedef struct {
      logic [1:0]  req;
      logic [15:0] len0;
      logic [15:0] len1;
      logic [1:0]  bpsk;
      int          sym;
      logic [1:0]  e_grant;
      logic [15:0] e_len;
      logic        e_bpsk;
      logic        e_zero;
   } vec_t;

   vec_t vt [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] outs();
      return {grant, src_sel, pkt_length, pkt_is_bpsk, pkt_en, busy, pkt_done, err_abort, err_zero_len};
   endfunction

   function automatic logic [24:0] t_outs();
      return {t_grant, t_src_sel, t_pkt_length, t_pkt_is_bpsk, t_pkt_en, t_busy, t_pkt_done,
              t_err_abort, t_err_zero_len};
   endfunction

   // One clock: wait for the falling edge, then drive the packetizer reaction to pkt_en.
   task automatic step();
      @(negedge clk);
      if (tx_tvalid && tx_tready) begin
         pz_sent++;
         if (tx_tlast) pz_phase = 4;
      end
      if (!pkt_en) begin
         pz_phase = 0;
      end else begin
         case (pz_phase)
            0: begin pz_phase = 1; pz_wait = pz_hdr_dly; end
            1: if (pz_wait == 0) pz_phase = 2; else pz_wait--;
            2: begin pz_phase = 3; pz_sent = 0; end
            default: ;
         endcase
      end
      hdr_vld   = (pz_phase == 2 || pz_phase == 3);
      tx_tvalid = (pz_phase == 3);
      tx_tready = tx_tvalid && (pz_stall ? ($urandom_range(0, 1) == 1) : 1'b1);
      tx_tlast  = tx_tvalid && (pz_sent == pz_len - 1);
   endtask

   task automatic do_reset();
      req = 2'b00;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (grant == 2'b00 && lat < 200);
   endtask

   // From a grant sample: run to pkt_done, then measure the idle gap.
   task automatic finish_pkt(input string name, input logic e_sel, input logic [15:0] e_len);
      int n = 0;
      int hold_bad = 0;
      int gap_n = 0;
      int dn = 0;
      while (!pkt_done && n < 3000) begin
         if (src_sel !== e_sel || pkt_length !== e_len) hold_bad++;
         step();
         n++;
      end
      check({name, "_done"}, pkt_done, 1'b1);
      check({name, "_hold"}, hold_bad, 0);
      check({name, "_en_off"}, pkt_en, 1'b0);
      while (busy && gap_n < 50) begin
         dn += int'(pkt_done);
         gap_n++;
         step();
      end
      check({name, "_gap"}, gap_n, GAP);
      check({name, "_done_once"}, dn, 1);
   endtask

   initial begin
      int lat, n, early, done_seen;
      logic [1:0] exp_g;
      logic [1:0] r_req, r_bpsk;
      logic [15:0] r_len0, r_len1;
      logic r_acc, w, m_last, m_busy, m_sel, m_bpsk;
      logic [15:0] m_len;
      int m_gap;
      logic [1:0] e_grant;
      logic e_zero, e_done;
      logic [1:0] act;

      vt[0] = '{2'b01, 16'd16,    16'd0,   2'b01, 336, 2'b01, 16'd16,    1'b1, 1'b0};
      vt[1] = '{2'b10, 16'd0,     16'd100, 2'b00, 20,  2'b10, 16'd100,   1'b0, 1'b0};
      vt[2] = '{2'b11, 16'd5,     16'd7,   2'b10, 3,   2'b01, 16'd5,     1'b0, 1'b0};
      vt[3] = '{2'b11, 16'd5,     16'd7,   2'b10, 1,   2'b10, 16'd7,     1'b1, 1'b0};
      vt[4] = '{2'b10, 16'd9,     16'd0,   2'b11, 1,   2'b10, 16'd0,     1'b1, 1'b1};
      vt[5] = '{2'b11, 16'd3,     16'd9,   2'b11, 2,   2'b01, 16'd3,     1'b1, 1'b0};
      vt[6] = '{2'b01, 16'd0,     16'd4,   2'b00, 1,   2'b01, 16'd0,     1'b0, 1'b1};
      vt[7] = '{2'b11, 16'd20,    16'd0,   2'b01, 1,   2'b10, 16'd0,     1'b0, 1'b1};
      vt[8] = '{2'b11, 16'hFFFF,  16'd1,   2'b01, 5,   2'b01, 16'hFFFF,  1'b1, 1'b0};

      // reset state
      do_reset();
      check("reset_outs", outs(), RST_OUTS);
      check("reset_outs_to", t_outs(), RST_OUTS);

      // table-driven arbitration vectors
      for (int i = 0; i < 9; i++) begin
         req_len0 = vt[i].len0;
         req_len1 = vt[i].len1;
         req_bpsk = vt[i].bpsk;
         pz_len   = vt[i].sym;
         req      = vt[i].req;
         wait_grant(lat);
         check($sformatf("v%0d_lat", i), lat, 1);
         check($sformatf("v%0d_grant", i), grant, vt[i].e_grant);
         check($sformatf("v%0d_sel", i), src_sel, vt[i].e_grant[1]);
         check($sformatf("v%0d_len", i), pkt_length, vt[i].e_len);
         check($sformatf("v%0d_bpsk", i), pkt_is_bpsk, vt[i].e_bpsk);
         check($sformatf("v%0d_zero", i), err_zero_len, vt[i].e_zero);
         check($sformatf("v%0d_busy", i), busy, !vt[i].e_zero);
         req = 2'b00;
         if (!vt[i].e_zero) begin
            finish_pkt($sformatf("v%0d", i), vt[i].e_grant[1], vt[i].e_len);
         end else begin
            n = 0;
            for (int k = 0; k < 3; k++) begin
               step();
               n += int'(busy) + int'(pkt_en) + int'(grant != 2'b00);
            end
            check($sformatf("v%0d_stay_idle", i), n, 0);
         end
      end

      // contention: both held for four packets
      do_reset();
      req_len0 = 16'd12;
      req_len1 = 16'd34;
      req_bpsk = 2'b01;
      pz_len = 6;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_grant(lat);
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         check($sformatf("rr%0d_grant", k), grant, exp_g);
         check($sformatf("rr%0d_lat", k), lat, 1);
         if (k == 3) req = 2'b00;
         finish_pkt($sformatf("rr%0d", k), exp_g[1], exp_g[1] ? 16'd34 : 16'd12);
      end

      // request arriving during the gap
      do_reset();
      pz_len = 10;
      req_len0 = 16'd16;
      req_bpsk = 2'b10;
      req = 2'b01;
      wait_grant(lat);
      req = 2'b00;
      n = 0;
      while (!pkt_done && n < 500) begin step(); n++; end
      check("gap_done", pkt_done, 1'b1);
      step();
      req_len1 = 16'd77;
      req = 2'b10;
      n = 0;
      early = 0;
      while (busy && n < 50) begin
         early += int'(grant != 2'b00);
         step();
         n++;
      end
      early += int'(grant != 2'b00);
      check("gap_no_grant", early, 0);
      wait_grant(lat);
      check("gap_grant", grant, 2'b10);
      check("gap_grant_lat", lat, 1);
      check("gap_grant_bpsk", pkt_is_bpsk, 1'b1);
      req = 2'b00;
      finish_pkt("gap_pkt", 1'b1, 16'd77);

      // reset in the middle of a ch0 packet
      do_reset();
      pz_len = 200;
      req_len0 = 16'd40;
      req_bpsk = 2'b01;
      req = 2'b01;
      wait_grant(lat);
      req = 2'b00;
      repeat (20) step();
      check("mid_active", {busy, pkt_en}, 2'b11);
      rst_n = 1'b0;
      step();
      check("mid_reset", outs(), RST_OUTS);
      rst_n = 1'b1;
      req_len0 = 16'd5;
      req_len1 = 16'd6;
      pz_len = 4;
      req = 2'b11;
      wait_grant(lat);
      check("mid_regrant", grant, 2'b01);
      check("mid_regrant_lat", lat, 1);
      req = 2'b00;
      finish_pkt("mid_pkt", 1'b0, 16'd5);

      // timeout with no header from the packetizer
      do_reset();
      pz_len = 8;
      pz_hdr_dly = 0;
      req_len0 = 16'd10;
      req_bpsk = 2'b01;
      req = 2'b01;
      n = 0;
      do begin step(); n++; end while (t_grant == 2'b00 && n < 20);
      check("to_grant", t_grant, 2'b01);
      req = 2'b00;
      n = 0;
      done_seen = 0;
      do begin
         step();
         n++;
         done_seen += int'(t_pkt_done);
      end while (!t_err_abort && n < 200);
      check("to_latency", n, 51);
      check("to_state", {t_err_abort, t_pkt_en, t_busy}, 3'b101);
      check("to_no_done", done_seen, 0);
      step();
      check("to_pulse", t_err_abort, 1'b0);

      // randomized traffic against the arbitration-level model
      do_reset();
      pz_stall = 1'b1;
      act = 2'b00;
      m_last = 1'b1;
      m_busy = 1'b0;
      m_gap = -1;
      m_sel = 1'b0;
      m_len = 16'd0;
      m_bpsk = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (pz_phase == 0) begin
            pz_hdr_dly = $urandom_range(0, 3);
            pz_len = $urandom_range(1, 40);
         end
         r_req  = req;
         r_len0 = req_len0;
         r_len1 = req_len1;
         r_bpsk = req_bpsk;
         r_acc  = tx_tvalid && tx_tready && tx_tlast;
         step();
         e_grant = 2'b00;
         e_zero = 1'b0;
         e_done = 1'b0;
         if (!m_busy) begin
            if (r_req != 2'b00) begin
               w = (r_req == 2'b11) ? !m_last : r_req[1];
               m_last = w;
               e_grant = w ? 2'b10 : 2'b01;
               m_sel = w;
               m_len = w ? r_len1 : r_len0;
               m_bpsk = r_bpsk[w];
               if (m_len == 16'd0) begin
                  e_zero = 1'b1;
               end else begin
                  m_busy = 1'b1;
                  m_gap = -1;
               end
            end
         end else if (m_gap < 0) begin
            if (r_acc) begin
               e_done = 1'b1;
               m_gap = GAP - 1;
            end
         end else if (m_gap == 0) begin
            m_busy = 1'b0;
         end else begin
            m_gap--;
         end
         check("rand_ctl", {grant, err_zero_len, pkt_done, err_abort, busy},
               {e_grant, e_zero, e_done, 1'b0, m_busy});
         if (e_grant != 2'b00 || m_busy) begin
            check("rand_latch", {src_sel, pkt_length, pkt_is_bpsk}, {m_sel, m_len, m_bpsk});
         end
         if (!m_busy || m_gap >= 0) begin
            check("rand_en_low", pkt_en, 1'b0);
         end else if (e_grant == 2'b00) begin
            check("rand_en_high", pkt_en, 1'b1);
         end
         for (int ch = 0; ch < 2; ch++) begin
            if (grant[ch]) begin
               act[ch] = 1'b0;
            end else if (act[ch] && $urandom_range(0, 59) == 0) begin
               act[ch] = 1'b0;
            end else if (!act[ch] && $urandom_range(0, 7) == 0) begin
               act[ch] = 1'b1;
               req_bpsk[ch] = ($urandom_range(0, 1) == 1);
               if (ch == 0) req_len0 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
               else         req_len1 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            end
         end
         req = act;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
